iter_alu: RTL and testbench



---
 rtl/alu_pkg.sv | 35 +++
 rtl/mdu_iter.sv | 109 ++++++++++
 rtl/iter_alu.sv | 138 +++++++++++++
 tb/tb_iter_alu.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM states and helpers shared by iter_alu and its bench.
package alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULT  = 4'b0011;
  localparam logic [3:0] OP_MULTU = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MFHI  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiplier / restoring divider on operand magnitudes.
module mdu_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         is_div,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int SW = $clog2(W);

  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic           run_q, run_d, div_q, div_d;
  logic           negq_q, negq_d, negr_q, negr_d, div0_q, div0_d;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     mul_sum, div_shift, div_diff;
  logic [2*W-1:0] prod, prod_fix;
  logic [W-1:0]   quo, rem;

  assign a_mag = (is_signed && a[W-1]) ? -a : a;
  assign b_mag = (is_signed && b[W-1]) ? -b : b;

  // hi_q is the accumulator (mul) or partial remainder (div); lo_q shifts the other operand out.
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
  assign div_shift = {hi_q, lo_q[W-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    div_d  = div_q;
    negq_d = negq_q;
    negr_d = negr_q;
    div0_d = div0_q;
    if (start) begin
      hi_d   = '0;
      lo_d   = a_mag;
      b_d    = b_mag;
      cnt_d  = SW'(W - 1);
      run_d  = 1'b1;
      div_d  = is_div;
      negq_d = is_signed & (a[W-1] ^ b[W-1]);
      negr_d = is_signed & is_div & a[W-1];
      div0_d = is_div & (b == '0);
    end else if (run_q) begin
      if (div_q) begin
        if (!div_diff[W]) begin
          hi_d = div_diff[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = div_shift[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[W:1];
        lo_d = {mul_sum[0], lo_q[W-1:1]};
      end
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      div_q  <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      div0_q <= div0_d;
    end
  end

  assign done = run_q && (cnt_q == '0);

  // Sign fix-up; a zero divisor yields an all-ones quotient and the dividend as remainder.
  assign prod     = {hi_q, lo_q};
  assign prod_fix = negq_q ? -prod : prod;
  assign quo      = div0_q ? '1 : (negq_q ? -lo_q : lo_q);
  assign rem      = negr_q ? -hi_q : hi_q;

  assign hi = div_q ? rem : prod_fix[2*W-1:W];
  assign lo = div_q ? quo : prod_fix[W-1:0];

endmodule

// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - registered ALU with single-cycle ops and iterative mul/div into HI/LO.
module iter_alu
  import alu_pkg::*;
#(
  parameter int W = 32,
  localparam int SW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [3:0]    i_op,
  input  logic [W-1:0]  i_data1,
  input  logic [W-1:0]  i_data2,
  input  logic [SW-1:0] shamt,
  output logic          o_valid,
  output logic [W-1:0]  o_result,
  output logic          o_zero,
  output logic [W-1:0]  o_hi,
  output logic [W-1:0]  o_lo
);

  state_e        state_q, state_d;
  logic [3:0]    op_q, op_d;
  logic [W-1:0]  d1_q, d1_d, d2_q, d2_d;
  logic [SW-1:0] sh_q, sh_d;
  logic          pend_q, pend_d, valid_q, valid_d;
  logic [W-1:0]  result_q, result_d, hi_q, hi_d, lo_q, lo_d;
  logic [W-1:0]  alu_res, mdu_hi, mdu_lo;
  logic          accept, md_op, mdu_start, mdu_done;

  assign accept    = i_valid && (state_q == S_IDLE);
  assign md_op     = is_muldiv(i_op);
  assign mdu_start = accept && md_op;

  mdu_iter #(.W(W)) u_mdu (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (mdu_start),
    .is_div    (i_op[3]),
    .is_signed (is_signed_op(i_op)),
    .a         (i_data1),
    .b         (i_data2),
    .done      (mdu_done),
    .hi        (mdu_hi),
    .lo        (mdu_lo)
  );

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_AND:  alu_res = d1_q & d2_q;
      OP_OR:   alu_res = d1_q | d2_q;
      OP_ADD:  alu_res = d1_q + d2_q;
      OP_SUB:  alu_res = d1_q - d2_q;
      OP_NOR:  alu_res = ~(d1_q | d2_q);
      OP_SLT:  alu_res = {{(W-1){1'b0}}, $signed(d1_q) < $signed(d2_q)};
      OP_SLTU: alu_res = {{(W-1){1'b0}}, d1_q < d2_q};
      OP_SLL:  alu_res = d2_q << sh_q;
      OP_SRL:  alu_res = d2_q >> sh_q;
      OP_SRA:  alu_res = $signed(d2_q) >>> sh_q;
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  // Single-cycle ops: operands captured on accept, result registered one edge later.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    d1_d     = d1_q;
    d2_d     = d2_q;
    sh_d     = sh_q;
    pend_d   = 1'b0;
    valid_d  = 1'b0;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (accept) begin
      op_d   = i_op;
      d1_d   = i_data1;
      d2_d   = i_data2;
      sh_d   = shamt;
      pend_d = !md_op;
    end
    if (pend_q) begin
      result_d = alu_res;
      valid_d  = 1'b1;
    end
    case (state_q)
      S_IDLE: if (mdu_start) state_d = S_RUN;
      S_RUN:  if (mdu_done) state_d = S_DONE;
      S_DONE: begin
        hi_d     = mdu_hi;
        lo_d     = mdu_lo;
        result_d = mdu_lo;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      d1_q     <= '0;
      d2_q     <= '0;
      sh_q     <= '0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      d1_q     <= d1_d;
      d2_q     <= d2_d;
      sh_q     <= sh_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_zero   = (result_q == '0);
  assign o_hi     = hi_q;
  assign o_lo     = lo_q;

endmodule

// File: tb/tb_iter_alu.sv
// tb/tb_iter_alu.sv - directed vector bench for iter_alu at W=32.
module tb_iter_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [3:0]  i_op = '0;
  logic [31:0] i_data1 = '0, i_data2 = '0;
  logic [4:0]  shamt = '0;
  logic        o_valid, o_zero;
  logic [31:0] o_result, o_hi, o_lo;

  int n_cmp = 0;
  int n_fail = 0;

  iter_alu #(.W(32)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_op     (i_op),
    .i_data1  (i_data1),
    .i_data2  (i_data2),
    .shamt    (shamt),
    .o_valid  (o_valid),
    .o_result (o_result),
    .o_zero   (o_zero),
    .o_hi     (o_hi),
    .o_lo     (o_lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] s);
    i_valid = 1'b1;
    i_op    = op;
    i_data1 = a;
    i_data2 = b;
    shamt   = s;
  endtask

  task automatic single(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    @(negedge clk);
    drive(op, a, b, 5'd0);
    @(posedge clk);
    #1 i_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({name, " valid"}, 64'(o_valid), 64'd1);
    chk({name, " result"}, 64'(o_result), 64'(exp));
  endtask

  // Issues a mul/div, injects an AND while busy, and checks latency, pulse count and HI/LO.
  task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int lat = 0;
    int pulses = 0;
    logic [31:0] res = '0;
    @(negedge clk);
    drive(op, a, b, 5'd0);
    @(posedge clk);
    #1 i_valid = 1'b0;
    chk({name, " busy"}, 64'(o_ready), 64'd0);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 5) drive(OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
      if (k == 7) i_valid = 1'b0;
      if (o_valid) begin
        pulses++;
        if (lat == 0) lat = k;
        res = o_result;
      end
    end
    chk({name, " latency"}, 64'(lat), 64'd33);
    chk({name, " pulses"}, 64'(pulses), 64'd1);
    chk({name, " result"}, 64'(res), 64'(exp_lo));
    chk({name, " hi"}, 64'(o_hi), 64'(exp_hi));
    chk({name, " lo"}, 64'(o_lo), 64'(exp_lo));
  endtask

  initial begin
    int pulses;
    vecs[0]  = '{OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
    vecs[1]  = '{OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001};
    vecs[2]  = '{OP_SRA,  32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000};
    vecs[3]  = '{OP_SRL,  32'h0,         32'h8000_0000, 5'd4,  32'h0800_0000};
    vecs[4]  = '{OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
    vecs[5]  = '{OP_AND,  32'hF0F0_A5A5, 32'h0FF0_FFFF, 5'd0,  32'h00F0_A5A5};
    vecs[6]  = '{OP_OR,   32'h1234_0000, 32'h0000_5678, 5'd0,  32'h1234_5678};
    vecs[7]  = '{OP_SUB,  32'h0000_0005, 32'h0000_0007, 5'd0,  32'hFFFF_FFFE};
    vecs[8]  = '{OP_NOR,  32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF};
    vecs[9]  = '{OP_SLL,  32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[10] = '{OP_MFHI, 32'h0,         32'h0,         5'd0,  32'h0000_0000};

    #1 reset_n = 1'b0;
    #3;
    chk("reset valid", 64'(o_valid), 64'd0);
    chk("reset result", 64'(o_result), 64'd0);
    chk("reset hi", 64'(o_hi), 64'd0);
    chk("reset lo", 64'(o_lo), 64'd0);
    chk("reset ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;

    // Back-to-back: vector k is driven at negedge k and its result is visible at negedge k+2.
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      chk($sformatf("b2b ready %0d", k), 64'(o_ready), 64'd1);
      if (k >= 2) begin
        chk($sformatf("vec%0d valid", k - 2), 64'(o_valid), 64'd1);
        chk($sformatf("vec%0d result", k - 2), 64'(o_result), 64'(vecs[k-2].exp));
        chk($sformatf("vec%0d zero", k - 2), 64'(o_zero), 64'(vecs[k-2].exp == 32'h0));
      end
      if (k < 11) drive(vecs[k].op, vecs[k].d1, vecs[k].d2, vecs[k].sh);
      else        i_valid = 1'b0;
    end
    @(negedge clk);
    chk("idle valid", 64'(o_valid), 64'd0);
    chk("idle hold", 64'(o_result), 64'h0000_0000);

    run_md("mult", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    single("mfhi", OP_MFHI, 32'h0, 32'h0, 32'hFFFF_FFFF);
    single("mflo", OP_MFLO, 32'h0, 32'h0, 32'hFFFF_FFEB);
    run_md("div", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_md("div pos/neg", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_md("divu by 0", OP_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF);
    run_md("div by 0", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_md("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_md("divu", OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF);
    run_md("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

    @(negedge clk);
    drive(OP_MULT, 32'h0000_1234, 32'h0000_5678, 5'd0);
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("abort valid", 64'(o_valid), 64'd0);
    chk("abort result", 64'(o_result), 64'd0);
    chk("abort hi", 64'(o_hi), 64'd0);
    chk("abort lo", 64'(o_lo), 64'd0);
    chk("abort ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) pulses++;
    end
    chk("abort no valid", 64'(pulses), 64'd0);
    chk("abort ready after", 64'(o_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
